// File: rtl/gate_rd_pkg.sv
// Shared types and constants for the gate result reader.
// Entry layout is {a, b, y[5:0]} with y1 (AND) in bit 0.
package gate_rd_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int RES_W     = 8;

    localparam int Y_AND  = 0;
    localparam int Y_OR   = 1;
    localparam int Y_NAND = 2;
    localparam int Y_NOR  = 3;
    localparam int Y_XOR  = 4;
    localparam int Y_XNOR = 5;

    typedef struct packed {
        logic       a;
        logic       b;
        logic [5:0] y;
    } entry_t;

endpackage

// File: rtl/gate_mux2.sv
// 2:1 multiplexer, the single primitive every gate is built from.
// y follows i1 when sel is high, else i0.
module gate_mux2 (
    input  logic i0,
    input  logic i1,
    input  logic sel,
    output logic y
);

    assign y = sel ? i1 : i0;

endmodule

// File: rtl/gate_result_reader.sv
// Evaluates six 2-input gates from mux primitives and queues
// {a, b, results} in a FIFO drained with 1-cycle read latency.
module gate_result_reader
    import gate_rd_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_a,
    input  logic                     req_b,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [RES_W-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     err_underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic       nb;
    logic [5:0] y;
    entry_t     wr_e;

    // a selects between the b-dependent half of each truth table
    gate_mux2 u_nb (
        .i0(1'b1), .i1(1'b0), .sel(req_b), .y(nb)
    );
    gate_mux2 u_and (
        .i0(1'b0), .i1(req_b), .sel(req_a), .y(y[Y_AND])
    );
    gate_mux2 u_or (
        .i0(req_b), .i1(1'b1), .sel(req_a), .y(y[Y_OR])
    );
    gate_mux2 u_nand (
        .i0(1'b1), .i1(nb), .sel(req_a), .y(y[Y_NAND])
    );
    gate_mux2 u_nor (
        .i0(nb), .i1(1'b0), .sel(req_a), .y(y[Y_NOR])
    );
    gate_mux2 u_xor (
        .i0(req_b), .i1(nb), .sel(req_a), .y(y[Y_XOR])
    );
    gate_mux2 u_xnor (
        .i0(nb), .i1(req_b), .sel(req_a), .y(y[Y_XNOR])
    );

    assign wr_e = {req_a, req_b, y};

    entry_t          mem [DEPTH];
    entry_t          rd_q;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            pop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign req_ready = !full;
    assign push      = req_valid && req_ready;
    assign pop       = rd_en && !empty;
    assign rd_data   = rd_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_e;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            rd_valid      <= 1'b0;
            rd_q          <= '0;
            err_underflow <= 1'b0;
        end else begin
            rd_valid <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                rd_q   <= mem[rd_ptr];
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (rd_en && empty) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule
